vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator, successor to the fixed 768x512 sync counter.
- Produces registered hsync/vsync with programmable porches and polarity, plus active-video flag, pixel coordinates and frame/line strobes.
- Advances on a pixel-enable tick so it runs from the board system clock.
- Sits between the clock-enable divider and the air-hockey renderer; the renderer draws from `hcount`/`vcount`/`video_on`.

---
 rtl/vga_timing_gen.sv | 200 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. It replaces the old fixed
// 768x512 sync counter. It runs from the board system clock and advances
// one pixel position on every clock edge where pix_en is high.
// Line order is active, front porch, sync, back porch. Lines within a
// frame follow the same order.
//
// Every output is registered and is computed from the next-state counters.
// Sync, video_on and the strobes therefore describe the same pixel that
// hcount/vcount show, with no extra latency.
//
// Optional feature (macro TEST_PATTERN_EN):
//    Adds vgaRed/vgaGreen/vgaBlue. These draw eight vertical colour bars
//    with a one-pixel white border around the visible area. The bars need
//    H_ACTIVE >= 8.
//
// Ports:
//    clk         system clock
//    rst         asynchronous active-high reset
//    pix_en      pixel tick; state advances only on edges where it is 1
//    hcount      current pixel column (CW bits)
//    vcount      current line (CW bits)
//    video_on    high inside the visible H_ACTIVE x V_ACTIVE area
//    Hsync       horizontal sync, asserted level HS_POL
//    Vsync       vertical sync, asserted level VS_POL
//    line_end    one-clk pulse when hcount becomes H_TOTAL-1
//    frame_start one-clk pulse when (hcount,vcount) becomes (0,0)
//    vgaRed/vgaGreen/vgaBlue  test-pattern colour (TEST_PATTERN_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CW       = 10,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   output logic [CW-1:0]      hcount,
   output logic [CW-1:0]      vcount,
   output logic               video_on,
   output logic               Hsync,
   output logic               Vsync,
   output logic               line_end,
   output logic               frame_start
`ifdef TEST_PATTERN_EN
   ,
   output logic [COLOR_W-1:0] vgaRed,
   output logic [COLOR_W-1:0] vgaGreen,
   output logic [COLOR_W-1:0] vgaBlue
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CW-1:0] r_hCount;
   logic [CW-1:0] r_vCount;
   logic          r_videoOn;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_lineEnd;
   logic          r_frameStart;

   logic [CW-1:0] w_hNext;
   logic [CW-1:0] w_vNext;
   logic          w_videoOn;
   logic          w_hsync;
   logic          w_vsync;

   // Next raster position. The column wraps at the end of each line. The
   // line counter moves only on that wrap, so Vsync changes on the same
   // tick as vcount.
   always_comb begin
      w_hNext = r_hCount + CW'(1);
      w_vNext = r_vCount;
      if (r_hCount == H_LAST) begin
         w_hNext = '0;
         if (r_vCount == V_LAST) begin
            w_vNext = '0;
         end else begin
            w_vNext = r_vCount + CW'(1);
         end
      end
   end

   // Decode the next position. The registers below then hold a value that
   // describes the counters stored beside them.
   always_comb begin
      w_videoOn = (w_hNext < H_ACT) && (w_vNext < V_ACT);
      w_hsync   = ((w_hNext >= HS_FIRST) && (w_hNext <= HS_LAST)) ? HS_POL : !HS_POL;
      w_vsync   = ((w_vNext >= VS_FIRST) && (w_vNext <= VS_LAST)) ? VS_POL : !VS_POL;
   end

   // Reset parks the counters on the last position of the frame. The first
   // pixel tick after reset therefore lands on (0,0) and fires frame_start.
   // The strobes are cleared on every clock and are set only on enabled
   // edges. This keeps them one clock wide however pix_en is driven.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hCount     <= H_LAST;
         r_vCount     <= V_LAST;
         r_videoOn    <= 1'b0;
         r_hsync      <= !HS_POL;
         r_vsync      <= !VS_POL;
         r_lineEnd    <= 1'b0;
         r_frameStart <= 1'b0;
      end else begin
         r_lineEnd    <= 1'b0;
         r_frameStart <= 1'b0;
         if (pix_en) begin
            r_hCount     <= w_hNext;
            r_vCount     <= w_vNext;
            r_videoOn    <= w_videoOn;
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            r_lineEnd    <= (w_hNext == H_LAST);
            r_frameStart <= (w_hNext == '0) && (w_vNext == '0);
         end
      end
   end

   assign hcount      = r_hCount;
   assign vcount      = r_vCount;
   assign video_on    = r_videoOn;
   assign Hsync       = r_hsync;
   assign Vsync       = r_vsync;
   assign line_end    = r_lineEnd;
   assign frame_start = r_frameStart;

`ifdef TEST_PATTERN_EN
   localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

   logic [COLOR_W-1:0] r_red;
   logic [COLOR_W-1:0] r_green;
   logic [COLOR_W-1:0] r_blue;

   logic [CW-1:0]      w_barFull;
   logic [2:0]         w_bar;
   logic               w_border;

   // The bar index comes from the next column, so the colour lines up with
   // video_on. If H_ACTIVE is not a multiple of 8, the leftover columns on
   // the right are clamped into the last bar.
   always_comb begin
      w_barFull = w_hNext / BAR_W;
      w_bar     = (w_barFull > CW'(7)) ? 3'd7 : w_barFull[2:0];
      w_border  = (w_hNext == '0) || (w_hNext == H_ACT - CW'(1)) ||
                  (w_vNext == '0) || (w_vNext == V_ACT - CW'(1));
   end

   // The colour registers follow the same enable and hold rules as the
   // timing outputs. They are forced to black outside the visible area.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else if (pix_en) begin
         if (!w_videoOn) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
         end else if (w_border) begin
            r_red   <= '1;
            r_green <= '1;
            r_blue  <= '1;
         end else begin
            r_red   <= {COLOR_W{w_bar[2]}};
            r_green <= {COLOR_W{w_bar[1]}};
            r_blue  <= {COLOR_W{w_bar[0]}};
         end
      end
   end

   assign vgaRed   = r_red;
   assign vgaGreen = r_green;
   assign vgaBlue  = r_blue;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Runs two generators side by side on one clock:
//    A - default 640x480 timing, active-low syncs
//    B - tiny 8/2/2/2 x 4/1/1/1 timing, active-high syncs, 4-bit counters
// The bench keeps each raster as a single linear position inside the frame.
// It derives the expected column, line, syncs, strobes and colours from
// that position with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
   localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
   localparam int B_HA = 8,   B_HF = 2,  B_HS = 2,  B_HB = 2;
   localparam int B_VA = 4,   B_VF = 1,  B_VS = 1,  B_VB = 1;
   localparam int A_TOTAL = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);
   localparam int B_TOTAL = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);
   localparam int COLW = 4;
   localparam int CMAX = (1 << COLW) - 1;

   typedef struct {
      int h;
      int v;
      bit von;
      bit hs;
      bit vs;
      bit le;
      bit fs;
      int r;
      int g;
      int b;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA, enA, rstB, enB;
   logic [9:0] hA, vA;
   logic [3:0] hB, vB;
   logic       vonA, hsA, vsA, leA, fsA;
   logic       vonB, hsB, vsB, leB, fsB;
`ifdef TEST_PATTERN_EN
   logic [COLW-1:0] rA, gA, bA, rB, gB, bB;
`endif

   vga_timing_gen dutA (
      .clk(clk), .rst(rstA), .pix_en(enA),
      .hcount(hA), .vcount(vA), .video_on(vonA),
      .Hsync(hsA), .Vsync(vsA), .line_end(leA), .frame_start(fsA)
`ifdef TEST_PATTERN_EN
      , .vgaRed(rA), .vgaGreen(gA), .vgaBlue(bA)
`endif
   );

   vga_timing_gen #(
      .CW(4), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(COLW)
   ) dutB (
      .clk(clk), .rst(rstB), .pix_en(enB),
      .hcount(hB), .vcount(vB), .video_on(vonB),
      .Hsync(hsB), .Vsync(vsB), .line_end(leB), .frame_start(fsB)
`ifdef TEST_PATTERN_EN
      , .vgaRed(rB), .vgaGreen(gB), .vgaBlue(bB)
`endif
   );

   int checkCount = 0;
   int passCount  = 0;
   int cycleCount = 0;

   // reference state: linear position in frame, "still in reset state" flag,
   // and whether the last clock edge was an enabled tick
   int posA, posB;
   bit freshA, freshB, tickA, tickB;

   // frame statistics for generator B
   int periodCnt, lineCnt, vonCnt, framesSeen, expPeriodB;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d",
                  tag, cycleCount, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   function automatic exp_t predict(input int pos, input bit fresh, input bit ticked,
                                    input int ha, input int hf, input int hsw, input int hb,
                                    input int va, input int vf, input int vsw, input int vb,
                                    input bit hp, input bit vp);
      exp_t e;
      int   ht, bar;
      ht  = ha + hf + hsw + hb;
      e.h = pos % ht;
      e.v = pos / ht;
      e.r = 0;
      e.g = 0;
      e.b = 0;
      if (fresh) begin
         e.von = 1'b0;
         e.hs  = !hp;
         e.vs  = !vp;
         e.le  = 1'b0;
         e.fs  = 1'b0;
         return e;
      end
      e.von = (e.h < ha) && (e.v < va);
      e.hs  = (e.h >= ha + hf && e.h < ha + hf + hsw) ? hp : !hp;
      e.vs  = (e.v >= va + vf && e.v < va + vf + vsw) ? vp : !vp;
      e.le  = ticked && (e.h == ht - 1);
      e.fs  = ticked && (pos == 0);
      if (e.von) begin
         if (e.h == 0 || e.h == ha - 1 || e.v == 0 || e.v == va - 1) begin
            e.r = CMAX;
            e.g = CMAX;
            e.b = CMAX;
         end else begin
            bar = e.h / (ha / 8);
            e.r = ((bar / 4) % 2 == 1) ? CMAX : 0;
            e.g = ((bar / 2) % 2 == 1) ? CMAX : 0;
            e.b = (bar % 2 == 1) ? CMAX : 0;
         end
      end
      return e;
   endfunction

   task automatic checkDutA(input string pfx);
      exp_t e;
      e = predict(posA, freshA, tickA, A_HA, A_HF, A_HS, A_HB,
                  A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0);
      checkOutput({pfx, "A.hcount"},      hA,   e.h);
      checkOutput({pfx, "A.vcount"},      vA,   e.v);
      checkOutput({pfx, "A.video_on"},    vonA, e.von);
      checkOutput({pfx, "A.Hsync"},       hsA,  e.hs);
      checkOutput({pfx, "A.Vsync"},       vsA,  e.vs);
      checkOutput({pfx, "A.line_end"},    leA,  e.le);
      checkOutput({pfx, "A.frame_start"}, fsA,  e.fs);
`ifdef TEST_PATTERN_EN
      checkOutput({pfx, "A.red"},   rA, e.r);
      checkOutput({pfx, "A.green"}, gA, e.g);
      checkOutput({pfx, "A.blue"},  bA, e.b);
`endif
   endtask

   task automatic checkDutB(input string pfx);
      exp_t e;
      e = predict(posB, freshB, tickB, B_HA, B_HF, B_HS, B_HB,
                  B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1);
      checkOutput({pfx, "B.hcount"},      hB,   e.h);
      checkOutput({pfx, "B.vcount"},      vB,   e.v);
      checkOutput({pfx, "B.video_on"},    vonB, e.von);
      checkOutput({pfx, "B.Hsync"},       hsB,  e.hs);
      checkOutput({pfx, "B.Vsync"},       vsB,  e.vs);
      checkOutput({pfx, "B.line_end"},    leB,  e.le);
      checkOutput({pfx, "B.frame_start"}, fsB,  e.fs);
`ifdef TEST_PATTERN_EN
      checkOutput({pfx, "B.red"},   rB, e.r);
      checkOutput({pfx, "B.green"}, gB, e.g);
      checkOutput({pfx, "B.blue"},  bB, e.b);
`endif
   endtask

   // One clock: drive enables, let the edge pass, advance the reference,
   // then compare both generators and collect B frame statistics.
   task automatic applyStimulus(input bit eA, input bit eB);
      enA = eA;
      enB = eB;
      @(posedge clk);
      #1;
      cycleCount++;
      if (rstA) begin
         posA = A_TOTAL - 1; freshA = 1'b1; tickA = 1'b0;
      end else if (eA) begin
         posA = (posA + 1) % A_TOTAL; freshA = 1'b0; tickA = 1'b1;
      end else begin
         tickA = 1'b0;
      end
      if (rstB) begin
         posB = B_TOTAL - 1; freshB = 1'b1; tickB = 1'b0;
      end else if (eB) begin
         posB = (posB + 1) % B_TOTAL; freshB = 1'b0; tickB = 1'b1;
      end else begin
         tickB = 1'b0;
      end
      checkDutA("");
      checkDutB("");
      if (fsB === 1'b1) begin
         if (framesSeen >= 1 && expPeriodB != 0) begin
            checkOutput("B.framePeriod",   periodCnt, expPeriodB);
            checkOutput("B.linesPerFrame", lineCnt,   B_VA + B_VF + B_VS + B_VB);
            checkOutput("B.activeTicks",   vonCnt,    B_HA * B_VA);
         end
         framesSeen++;
         periodCnt = 0;
         lineCnt   = 0;
         vonCnt    = 0;
      end
      periodCnt++;
      if (leB === 1'b1) lineCnt++;
      if (vonB === 1'b1 && tickB) vonCnt++;
   endtask

   task automatic newPhase(input int period);
      expPeriodB = period;
      framesSeen = 0;
      periodCnt  = 0;
      lineCnt    = 0;
      vonCnt     = 0;
   endtask

   initial begin
      rstA = 1'b1; rstB = 1'b1; enA = 1'b0; enB = 1'b0;
      posA = A_TOTAL - 1; posB = B_TOTAL - 1;
      freshA = 1'b1; freshB = 1'b1; tickA = 1'b0; tickB = 1'b0;
      newPhase(0);

      // reset state, with pix_en toggling to show it has no effect
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      rstA = 1'b0;
      rstB = 1'b0;

      // continuous pixel tick: A covers lines 0-2 including hsync, B many frames
      $display("[TB] continuous pix_en");
      newPhase(B_TOTAL);
      for (int i = 0; i < 1700; i++) applyStimulus(1'b1, 1'b1);

      // tick on every 4th clock
      $display("[TB] pix_en every 4th clock");
      newPhase(4 * B_TOTAL);
      for (int i = 0; i < 1600; i++) applyStimulus((i % 4) == 3, (i % 4) == 3);

      // random tick pattern
      $display("[TB] random pix_en");
      newPhase(0);
      for (int i = 0; i < 1500; i++)
         applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);

      // A: reset mid-line while Hsync is active (hcount 700)
      $display("[TB] reset during sync");
      rstA = 1'b1;
      applyStimulus(1'b1, 1'b1);
      rstA = 1'b0;
      for (int i = 0; i < 2000 && posA != 700; i++) applyStimulus(1'b1, $urandom_range(0, 1) != 0);
      checkOutput("A.reachedCol700", posA, 700);
      rstA = 1'b1;
      #2;
      posA = A_TOTAL - 1; freshA = 1'b1; tickA = 1'b0;
      checkDutA("asyncRst.");
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      rstA = 1'b0;

      // B: reset while both syncs are active (hcount 10, vcount 5)
      for (int i = 0; i < 400 && posB != 5 * 14 + 10; i++) applyStimulus($urandom_range(0, 1) != 0, 1'b1);
      checkOutput("B.reachedSyncPos", posB, 5 * 14 + 10);
      rstB = 1'b1;
      #2;
      posB = B_TOTAL - 1; freshB = 1'b1; tickB = 1'b0;
      checkDutB("asyncRst.");
      applyStimulus(1'b1, 1'b1);
      rstB = 1'b0;

      // recovery after reset with a random tick pattern
      newPhase(0);
      for (int i = 0; i < 1000; i++)
         applyStimulus($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
